reset_seq: RTL and testbench

Parametrised, single-clock reset sequencer for the BoxLambda SoC. It drives `NUM_DOMAINS` active-high reset outputs and generates the Power-On Reset after PLL lock. Each domain can be reset by hardware request sources (routed through a parameter mask), by software over Wishbone, or by loss of PLL lock. After the assert phase, domains are released in staggered ascending order. Sticky reset-reason and status registers sit on a 32-bit pipelined Wishbone slave.

---
 rtl/reset_seq_pkg.sv | 26 ++
 rtl/reset_seq_wb_regs.sv | 94 +++++++++
 rtl/reset_seq.sv | 207 ++++++++++++++++++++
 tb/tb_reset_seq.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
// Shared definitions for the reset sequencer: FSM states, register map
// and bit positions inside the REASON and STATUS registers.
package reset_seq_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_LOCK,
        ST_PRE_WAIT,
        ST_ASSERT,
        ST_RELEASE,
        ST_IDLE
    } state_t;

    localparam logic [1:0] ADDR_CTRL      = 2'd0;
    localparam logic [1:0] ADDR_REASON    = 2'd1;
    localparam logic [1:0] ADDR_PULSE_LEN = 2'd2;
    localparam logic [1:0] ADDR_STATUS    = 2'd3;

    localparam int REASON_POR      = 0;
    localparam int REASON_SW       = 1;
    localparam int REASON_LOCKLOSS = 2;
    localparam int REASON_SRC_BASE = 3;

    localparam int STATUS_BUSY_BIT     = 8;
    localparam int STATUS_POR_DONE_BIT = 9;

endpackage

// File: rtl/reset_seq_wb_regs.sv
// Wishbone slave for the reset sequencer: decodes accesses, holds the
// sticky REASON bits and the PULSE_LEN setting, and turns CTRL writes
// into a one-cycle software reset request.
module reset_seq_wb_regs
    import reset_seq_pkg::*;
#(
    parameter int NUM_DOMAINS   = 4,
    parameter int NUM_SRC       = 4,
    parameter int CNT_W         = 8,
    parameter int PULSE_LEN_RST = 64
) (
    input  logic                                sys_clk,
    input  logic                                rst,
    input  logic [1:0]                          wb_adr,
    input  logic [31:0]                         wb_dat_w,
    output logic [31:0]                         wb_dat_r,
    input  logic [3:0]                          wb_sel,
    input  logic                                wb_cyc,
    input  logic                                wb_stb,
    output logic                                wb_ack,
    input  logic                                wb_we,
    input  logic [REASON_SRC_BASE+NUM_SRC-1:0]  reason_set,
    input  logic [NUM_DOMAINS-1:0]              rst_state,
    input  logic                                busy,
    input  logic                                por_completed,
    output logic [CNT_W-1:0]                    pulse_len,
    output logic [NUM_DOMAINS-1:0]              sw_req
);

    localparam int REASON_W = REASON_SRC_BASE + NUM_SRC;

    logic                wr_en;
    logic                rd_en;
    logic [REASON_W-1:0] reason;
    logic [REASON_W-1:0] w1c;
    logic [31:0]         rd_word;
    logic                unused_wb;

    assign wr_en     = wb_cyc & wb_stb & wb_we;
    assign rd_en     = wb_cyc & wb_stb & ~wb_we;
    assign unused_wb = ^{wb_sel, wb_dat_w};

    // Write decode: CTRL becomes a one-shot request mask, REASON writes clear bits
    always_comb begin
        sw_req = '0;
        w1c    = '0;
        if (wr_en && wb_adr == ADDR_CTRL) begin
            sw_req = wb_dat_w[NUM_DOMAINS-1:0];
        end
        if (wr_en && wb_adr == ADDR_REASON) begin
            w1c = wb_dat_w[REASON_W-1:0];
        end
    end

    // Sticky reason bits (a set in the same cycle as a clear wins) and pulse length
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            reason    <= '0;
            pulse_len <= CNT_W'(PULSE_LEN_RST);
        end else begin
            reason <= (reason & ~w1c) | reason_set;
            if (wr_en && wb_adr == ADDR_PULSE_LEN) begin
                pulse_len <= wb_dat_w[CNT_W-1:0];
            end
        end
    end

    // Read multiplexer; unused bits and the write-only CTRL read as zero
    always_comb begin
        rd_word = '0;
        case (wb_adr)
            ADDR_REASON:    rd_word[REASON_W-1:0] = reason;
            ADDR_PULSE_LEN: rd_word[CNT_W-1:0]    = pulse_len;
            ADDR_STATUS: begin
                rd_word[NUM_DOMAINS-1:0]    = rst_state;
                rd_word[STATUS_BUSY_BIT]    = busy;
                rd_word[STATUS_POR_DONE_BIT] = por_completed;
            end
            default:        rd_word = '0;
        endcase
    end

    // Single-cycle acknowledge with read data registered alongside it
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            wb_ack   <= 1'b0;
            wb_dat_r <= '0;
        end else begin
            wb_ack   <= wb_stb & wb_cyc;
            wb_dat_r <= rd_en ? rd_word : 32'h0;
        end
    end

endmodule

// File: rtl/reset_seq.sv
// Reset sequencer top: waits for PLL lock, runs the power-on reset, then
// services hardware and software reset requests per domain, releasing
// the domains one after another in ascending order.
module reset_seq
    import reset_seq_pkg::*;
#(
    parameter int                             NUM_DOMAINS   = 4,
    parameter int                             NUM_SRC       = 4,
    parameter logic [NUM_SRC*NUM_DOMAINS-1:0] SRC_MAP       = '1,
    parameter int                             CNT_W         = 8,
    parameter int                             POR_WAIT      = 64,
    parameter int                             PULSE_LEN_RST = 64,
    parameter int                             STAGGER       = 8
) (
    input  logic                   sys_clk,
    input  logic                   rst,
    input  logic                   pll_locked_i,
    input  logic [NUM_SRC-1:0]     req_i,
    output logic [NUM_DOMAINS-1:0] rst_o,
    output logic                   por_completed_o,
    input  logic [1:0]             wb_adr,
    input  logic [31:0]            wb_dat_w,
    output logic [31:0]            wb_dat_r,
    input  logic [3:0]             wb_sel,
    output logic                   wb_stall,
    input  logic                   wb_cyc,
    input  logic                   wb_stb,
    output logic                   wb_ack,
    input  logic                   wb_we,
    output logic                   wb_err
);

    localparam int REASON_W = REASON_SRC_BASE + NUM_SRC;
    localparam int PRE_W    = $clog2(POR_WAIT + 1);
    localparam int REL_LAST = (NUM_DOMAINS - 1) * STAGGER;
    localparam int REL_W    = $clog2(REL_LAST + 2);

    state_t                 state_q, state_n;
    logic [PRE_W-1:0]       pre_cnt_q, pre_cnt_n;
    logic [CNT_W-1:0]       asrt_cnt_q, asrt_cnt_n;
    logic [REL_W-1:0]       rel_cnt_q, rel_cnt_n;
    logic [NUM_DOMAINS-1:0] mask_q, mask_n;
    logic [NUM_DOMAINS-1:0] pending_q, pending_n;
    logic [NUM_DOMAINS-1:0] rst_o_n;
    logic [NUM_DOMAINS-1:0] routed;
    logic [NUM_DOMAINS-1:0] sw_req;
    logic [NUM_DOMAINS-1:0] pend_all;
    logic [NUM_SRC-1:0]     src_hit;
    logic [REASON_W-1:0]    reason_set;
    logic [CNT_W-1:0]       pulse_len;
    logic [CNT_W-1:0]       pulse_eff;
    logic                   lock_loss;
    logic                   por_last;
    logic                   busy;

    assign wb_stall  = 1'b0;
    assign wb_err    = 1'b0;
    assign lock_loss = (state_q != ST_WAIT_LOCK) && !pll_locked_i;
    assign pend_all  = pending_q | routed | sw_req;
    assign pulse_eff = (pulse_len == '0) ? CNT_W'(1) : pulse_len;
    assign por_last  = (state_q == ST_PRE_WAIT) && (int'(pre_cnt_q) == POR_WAIT - 1);
    assign busy      = (state_q != ST_IDLE);

    // Route each hardware source onto its domains and note which sources fired
    always_comb begin
        routed  = '0;
        src_hit = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            for (int d = 0; d < NUM_DOMAINS; d++) begin
                if (req_i[s] && SRC_MAP[s*NUM_DOMAINS+d]) begin
                    routed[d]  = 1'b1;
                    src_hit[s] = 1'b1;
                end
            end
        end
    end

    // State, counters, request bookkeeping and the registered reset outputs
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q         <= ST_WAIT_LOCK;
            pre_cnt_q       <= '0;
            asrt_cnt_q      <= '0;
            rel_cnt_q       <= '0;
            mask_q          <= '0;
            pending_q       <= '0;
            rst_o           <= '1;
            por_completed_o <= 1'b0;
        end else begin
            state_q    <= state_n;
            pre_cnt_q  <= pre_cnt_n;
            asrt_cnt_q <= asrt_cnt_n;
            rel_cnt_q  <= rel_cnt_n;
            mask_q     <= mask_n;
            pending_q  <= pending_n;
            rst_o      <= rst_o_n;
            if (state_n == ST_IDLE) begin
                por_completed_o <= 1'b1;
            end
        end
    end

    // Sequencing: lock loss overrides everything, requests outside IDLE accumulate
    always_comb begin
        state_n    = state_q;
        pre_cnt_n  = pre_cnt_q;
        asrt_cnt_n = asrt_cnt_q;
        rel_cnt_n  = rel_cnt_q;
        mask_n     = mask_q;
        pending_n  = pend_all;
        if (lock_loss) begin
            state_n   = ST_WAIT_LOCK;
            pending_n = '0;
        end else begin
            case (state_q)
                ST_WAIT_LOCK: begin
                    if (pll_locked_i) begin
                        state_n   = ST_PRE_WAIT;
                        pre_cnt_n = '0;
                    end
                end
                ST_PRE_WAIT: begin
                    if (por_last) begin
                        state_n    = ST_ASSERT;
                        mask_n     = '1;
                        asrt_cnt_n = pulse_eff;
                    end else begin
                        pre_cnt_n = pre_cnt_q + PRE_W'(1);
                    end
                end
                ST_ASSERT: begin
                    if (asrt_cnt_q <= CNT_W'(1)) begin
                        state_n   = ST_RELEASE;
                        rel_cnt_n = '0;
                    end else begin
                        asrt_cnt_n = asrt_cnt_q - CNT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    if (int'(rel_cnt_q) == REL_LAST) begin
                        state_n = ST_IDLE;
                    end else begin
                        rel_cnt_n = rel_cnt_q + REL_W'(1);
                    end
                end
                ST_IDLE: begin
                    if (pend_all != '0) begin
                        state_n    = ST_ASSERT;
                        mask_n     = pend_all;
                        asrt_cnt_n = pulse_eff;
                        pending_n  = '0;
                    end
                end
                default: state_n = ST_WAIT_LOCK;
            endcase
        end
    end

    // Next reset levels and the reason bits to latch this cycle
    always_comb begin
        rst_o_n    = '0;
        reason_set = '0;
        if (lock_loss) begin
            rst_o_n                     = '1;
            reason_set[REASON_LOCKLOSS] = 1'b1;
        end else begin
            case (state_q)
                ST_WAIT_LOCK, ST_PRE_WAIT: rst_o_n = '1;
                ST_ASSERT:                 rst_o_n = mask_q;
                ST_RELEASE: begin
                    for (int d = 0; d < NUM_DOMAINS; d++) begin
                        rst_o_n[d] = mask_q[d] && (int'(rel_cnt_q) < d * STAGGER);
                    end
                end
                default:                   rst_o_n = '0;
            endcase
            reason_set[REASON_SW]                         = |sw_req;
            reason_set[REASON_W-1:REASON_SRC_BASE]        = src_hit;
            reason_set[REASON_POR]                        = por_last && !por_completed_o;
        end
    end

    reset_seq_wb_regs #(
        .NUM_DOMAINS  (NUM_DOMAINS),
        .NUM_SRC      (NUM_SRC),
        .CNT_W        (CNT_W),
        .PULSE_LEN_RST(PULSE_LEN_RST)
    ) u_wb_regs (
        .sys_clk      (sys_clk),
        .rst          (rst),
        .wb_adr       (wb_adr),
        .wb_dat_w     (wb_dat_w),
        .wb_dat_r     (wb_dat_r),
        .wb_sel       (wb_sel),
        .wb_cyc       (wb_cyc),
        .wb_stb       (wb_stb),
        .wb_ack       (wb_ack),
        .wb_we        (wb_we),
        .reason_set   (reason_set),
        .rst_state    (rst_o),
        .busy         (busy),
        .por_completed(por_completed_o),
        .pulse_len    (pulse_len),
        .sw_req       (sw_req)
    );

endmodule

// File: tb/tb_reset_seq.sv
// Scoreboard bench for reset_seq: stimulus pushes expected rst_o edges and
// expected bus read data into queues; a monitor pops and compares them
// whenever rst_o changes or wb_ack is seen.
module tb_reset_seq;

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_REASON = 2'd1;
    localparam logic [1:0] A_PLEN   = 2'd2;
    localparam logic [1:0] A_STATUS = 2'd3;

    logic        sys_clk = 1'b0;
    logic        rst;
    logic        pll_locked_i;
    logic [3:0]  req_i;
    logic [3:0]  rst_o;
    logic        por_completed_o;
    logic [1:0]  wb_adr;
    logic [31:0] wb_dat_w;
    logic [31:0] wb_dat_r;
    logic [3:0]  wb_sel;
    logic        wb_stall;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_ack;
    logic        wb_we;
    logic        wb_err;

    typedef struct {
        int         at;
        logic [3:0] val;
    } rst_evt_t;

    typedef struct {
        bit          is_read;
        logic [31:0] exp;
        string       name;
    } bus_evt_t;

    rst_evt_t   rst_q[$];
    bus_evt_t   bus_q[$];
    int         cyc      = 0;
    int         checks   = 0;
    int         failures = 0;
    logic [3:0] prev_rst = 4'hF;

    // src0 -> all domains, src1 -> d0 only, src2 -> none, src3 -> d3 only
    reset_seq #(
        .NUM_DOMAINS  (4),
        .NUM_SRC      (4),
        .SRC_MAP      (16'h801F),
        .CNT_W        (8),
        .POR_WAIT     (64),
        .PULSE_LEN_RST(64),
        .STAGGER      (8)
    ) dut (
        .sys_clk        (sys_clk),
        .rst            (rst),
        .pll_locked_i   (pll_locked_i),
        .req_i          (req_i),
        .rst_o          (rst_o),
        .por_completed_o(por_completed_o),
        .wb_adr         (wb_adr),
        .wb_dat_w       (wb_dat_w),
        .wb_dat_r       (wb_dat_r),
        .wb_sel         (wb_sel),
        .wb_stall       (wb_stall),
        .wb_cyc         (wb_cyc),
        .wb_stb         (wb_stb),
        .wb_ack         (wb_ack),
        .wb_we          (wb_we),
        .wb_err         (wb_err)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void pushRst(input int at, input logic [3:0] val);
        rst_evt_t e;
        e.at  = at;
        e.val = val;
        rst_q.push_back(e);
    endfunction

    // One bus access driven from a falling edge; returns the sampling edge number
    task automatic applyStimulus(input string name, input logic [1:0] adr, input logic we,
                                 input logic [31:0] dat, input logic [31:0] exp, output int at);
        bus_evt_t e;
        wb_adr   = adr;
        wb_we    = we;
        wb_dat_w = dat;
        wb_cyc   = 1'b1;
        wb_stb   = 1'b1;
        e.is_read = !we;
        e.exp     = exp;
        e.name    = name;
        bus_q.push_back(e);
        at = cyc + 1;
        @(negedge sys_clk);
        wb_cyc   = 1'b0;
        wb_stb   = 1'b0;
        wb_we    = 1'b0;
        wb_dat_w = 32'h0;
    endtask

    task automatic wbWrite(input logic [1:0] adr, input logic [31:0] dat, output int at);
        applyStimulus("write", adr, 1'b1, dat, 32'h0, at);
    endtask

    task automatic wbRead(input string name, input logic [1:0] adr, input logic [31:0] exp);
        int unused_at;
        applyStimulus(name, adr, 1'b0, 32'h0, exp, unused_at);
    endtask

    task automatic waitUntil(input int c);
        while (cyc < c) @(negedge sys_clk);
    endtask

    // Monitor: compares rst_o edges and acknowledged reads against the queues
    always @(posedge sys_clk) begin : monitor
        rst_evt_t re;
        bus_evt_t be;
        #1;
        cyc++;
        if (rst_o !== prev_rst) begin
            if (rst_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL rst_o_unexpected actual=0x%0h expected=0x%0h (cycle %0d)", rst_o, prev_rst, cyc);
            end else begin
                re = rst_q.pop_front();
                checkOutput("rst_o_edge_cycle", 32'(cyc), 32'(re.at));
                checkOutput("rst_o_value", {28'h0, rst_o}, {28'h0, re.val});
            end
            prev_rst = rst_o;
        end
        if (wb_ack === 1'b1) begin
            if (bus_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL wb_ack_unexpected actual=1 expected=0 (cycle %0d)", cyc);
            end else begin
                be = bus_q.pop_front();
                if (be.is_read) checkOutput(be.name, wb_dat_r, be.exp);
            end
        end
    end

    initial begin : watchdog
        #(20000 * 10);
        $display("[TB] FAIL watchdog actual=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin : stimulus
        int n;
        int m;
        rst          = 1'b1;
        pll_locked_i = 1'b0;
        req_i        = 4'h0;
        wb_adr       = 2'd0;
        wb_dat_w     = 32'h0;
        wb_sel       = 4'hF;
        wb_cyc       = 1'b0;
        wb_stb       = 1'b0;
        wb_we        = 1'b0;

        // Reset state
        repeat (3) @(negedge sys_clk);
        checkOutput("reset_rst_o", {28'h0, rst_o}, 32'hF);
        checkOutput("reset_por_completed", {31'h0, por_completed_o}, 32'h0);
        checkOutput("reset_wb_ack", {31'h0, wb_ack}, 32'h0);
        checkOutput("reset_wb_dat_r", wb_dat_r, 32'h0);
        rst = 1'b0;
        wbRead("reset_reason", A_REASON, 32'h0);
        wbRead("reset_pulse_len", A_PLEN, 32'h40);
        wbRead("reset_status", A_STATUS, 32'h10F);
        wbRead("ctrl_reads_zero", A_CTRL, 32'h0);

        // POR: lock 10 cycles after reset release, 64 wait + 64 assert, stagger 8
        waitUntil(13);
        pll_locked_i = 1'b1;
        n = cyc + 1;
        pushRst(n + 64 + 1 + 64,      4'hE);
        pushRst(n + 64 + 1 + 64 + 8,  4'hC);
        pushRst(n + 64 + 1 + 64 + 16, 4'h8);
        pushRst(n + 64 + 1 + 64 + 24, 4'h0);
        waitUntil(n + 64 + 64 + 30);
        checkOutput("por_completed_high", {31'h0, por_completed_o}, 32'h1);
        wbRead("por_reason", A_REASON, 32'h1);
        wbRead("por_status", A_STATUS, 32'h200);

        // SW reset of d2 with PULSE_LEN = 5
        wbWrite(A_REASON, 32'h1, n);
        wbWrite(A_PLEN, 32'h5, n);
        wbRead("pulse_len_5", A_PLEN, 32'h5);
        wbWrite(A_CTRL, 32'h4, n);
        pushRst(n + 1, 4'h4);
        pushRst(n + 1 + 5 + 16, 4'h0);
        waitUntil(n + 32);
        wbRead("sw_reason", A_REASON, 32'h2);
        wbWrite(A_REASON, 32'h2, n);
        wbRead("sw_reason_cleared", A_REASON, 32'h0);

        // Source 1 routes only to d0
        req_i = 4'h2;
        n = cyc + 1;
        @(negedge sys_clk);
        req_i = 4'h0;
        pushRst(n + 1, 4'h1);
        pushRst(n + 1 + 5, 4'h0);
        waitUntil(n + 32);
        wbRead("src1_reason", A_REASON, 32'h10);
        wbWrite(A_REASON, 32'h10, n);

        // d3 request while d0 is being asserted
        wbWrite(A_CTRL, 32'h1, n);
        pushRst(n + 1, 4'h1);
        pushRst(n + 6, 4'h0);
        waitUntil(n + 1);
        wbWrite(A_CTRL, 32'h8, m);
        pushRst(n + 32, 4'h8);
        pushRst(n + 32 + 5 + 24, 4'h0);
        waitUntil(n + 64);
        wbRead("busy_req_status", A_STATUS, 32'h200);

        // Lock loss mid-RELEASE, then relock
        wbWrite(A_REASON, 32'h7F, n);
        wbWrite(A_CTRL, 32'hF, n);
        pushRst(n + 1, 4'hF);
        pushRst(n + 6, 4'hE);
        pushRst(n + 10, 4'hF);
        waitUntil(n + 9);
        pll_locked_i = 1'b0;
        @(negedge sys_clk);
        wbRead("lockloss_status", A_STATUS, 32'h30F);
        wbRead("lockloss_reason", A_REASON, 32'h6);
        pll_locked_i = 1'b1;
        m = cyc + 1;
        pushRst(m + 64 + 1 + 5,      4'hE);
        pushRst(m + 64 + 1 + 5 + 8,  4'hC);
        pushRst(m + 64 + 1 + 5 + 16, 4'h8);
        pushRst(m + 64 + 1 + 5 + 24, 4'h0);
        waitUntil(m + 97);
        wbRead("relock_reason", A_REASON, 32'h6);
        wbRead("relock_status", A_STATUS, 32'h200);

        // PULSE_LEN = 0 acts as 1; W1C and source set collide on bit 4
        wbWrite(A_PLEN, 32'h0, n);
        wbRead("pulse_len_0", A_PLEN, 32'h0);
        wbWrite(A_REASON, 32'h7F, n);
        req_i = 4'h2;
        wbWrite(A_REASON, 32'h10, n);
        req_i = 4'h0;
        pushRst(n + 1, 4'h1);
        pushRst(n + 2, 4'h0);
        waitUntil(n + 28);
        wbRead("set_beats_clear", A_REASON, 32'h10);

        // Drain, then flag anything the DUT never produced
        for (int i = 0; i < 50 && (rst_q.size() != 0 || bus_q.size() != 0); i++) begin
            @(negedge sys_clk);
        end
        while (rst_q.size() != 0) begin
            rst_evt_t e;
            e = rst_q.pop_front();
            checks++;
            failures++;
            $display("[TB] FAIL rst_o_missing actual=none expected=0x%0h at cycle %0d", e.val, e.at);
        end
        while (bus_q.size() != 0) begin
            bus_evt_t b;
            b = bus_q.pop_front();
            checks++;
            failures++;
            $display("[TB] FAIL wb_ack_missing %s actual=none expected=ack", b.name);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
